// File: rtl/ktane_mmio_pkg.sv
// Shared memory map, button bit indices and event layout for the KTANE peripheral bus.
// Also holds the poll FSM state encoding and the press/release event builder.
package ktane_mmio_pkg;

  localparam logic [15:0] BTN_RD_BASE   = 16'hF330;
  localparam logic [15:0] BTN_RD_END    = 16'hF663;
  localparam logic [15:0] LED_WR_BASE   = 16'hF000;
  localparam logic [15:0] LED_WR_END    = 16'hF100;
  localparam logic [15:0] STRIP_WR_BASE = 16'hF100;
  localparam logic [15:0] STRIP_WR_END  = 16'hF200;
  localparam logic [15:0] WORD_WR_BASE  = 16'hF200;
  localparam logic [15:0] WORD_WR_END   = 16'hF330;

  localparam int BTN_COUNT      = 8;
  localparam int BTN_BIG_BUTTON = 0;
  localparam int BTN_KEYPAD_LR  = 1;
  localparam int BTN_KEYPAD_LL  = 2;
  localparam int BTN_KEYPAD_TR  = 3;
  localparam int BTN_KEYPAD_TL  = 4;
  localparam int BTN_MORSE_TX   = 5;
  localparam int BTN_MORSE_RIGHT = 6;
  localparam int BTN_MORSE_LEFT = 7;

  localparam int EVT_WIDTH = 16;

  // Upper byte carries newly pressed bits, lower byte newly released bits.
  typedef struct packed {
    logic [BTN_COUNT-1:0] press;
    logic [BTN_COUNT-1:0] rel;
  } btn_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_STROBE,
    ST_CAPTURE,
    ST_PROCESS
  } poll_state_t;

  function automatic btn_evt_t make_evt(input logic [BTN_COUNT-1:0] oldLv,
                                        input logic [BTN_COUNT-1:0] newLv);
    btn_evt_t e;
    e.press = newLv & ~oldLv;
    e.rel   = ~newLv & oldLv;
    return e;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO; a push while full is taken only when a pop frees a slot in the same cycle.
// The output reads zero while the FIFO is empty.
module evt_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = empty ? '0 : mem[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/button_poll_master.sv
// Periodic bus initiator that reads the button window, debounces the eight button bits
// and queues press/release events for the CPU behind a valid/ready interface.
module button_poll_master
  import ktane_mmio_pkg::*;
#(
  parameter logic [15:0] POLL_ADDR        = 16'hF330,
  parameter int          POLL_PERIOD      = 50000,
  parameter int          DEBOUNCE_SAMPLES = 4,
  parameter int          FIFO_DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] addr,
  output logic        en,
  output logic        we,
  output logic [15:0] data,
  input  logic [15:0] q,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_data,
  output logic [7:0]  btn_state,
  output logic        irq,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_SAMPLES - 1);

  poll_state_t                     state_q;
  logic [TMR_W-1:0]                timer_q;
  logic                            busReq_q;
  logic [BTN_COUNT-1:0]            sample_q;
  logic [BTN_COUNT-1:0]            btnState_q;
  logic [BTN_COUNT-1:0]            btnState_d;
  logic [BTN_COUNT-1:0][CNT_W-1:0] cnt_q;
  logic [BTN_COUNT-1:0][CNT_W-1:0] cnt_d;
  logic                            ovf_q;
  btn_evt_t                        evt;
  logic                            push;
  logic                            fifoFull;
  logic                            fifoEmpty;
  logic                            unusedLowBits;

  assign unusedLowBits = ^q[7:0];

  // The strobe follows the grant combinationally so a withdrawn grant never reaches the bus.
  assign en        = (state_q == ST_STROBE) && bus_gnt;
  assign addr      = en ? POLL_ADDR : 16'h0000;
  assign bus_req   = busReq_q;
  assign we        = 1'b0;
  assign data      = 16'h0000;
  assign btn_state = btnState_q;
  assign ovf       = ovf_q;
  assign evt_valid = !fifoEmpty;
  assign irq       = evt_valid;

  always_comb begin
    btnState_d = btnState_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < BTN_COUNT; i++) begin
      if (sample_q[i] == btnState_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        btnState_d[i] = ~btnState_q[i];
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign evt  = make_evt(btnState_q, btnState_d);
  assign push = (state_q == ST_PROCESS) && (evt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= TMR_RELOAD;
      busReq_q   <= 1'b0;
      sample_q   <= '0;
      btnState_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (timer_q == '0) begin
            state_q  <= ST_REQ;
            busReq_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (bus_gnt) begin
            state_q <= ST_CAPTURE;
          end
        end
        // Peripheral data registered on the strobe edge is valid here.
        ST_CAPTURE: begin
          sample_q <= q[15:8];
          busReq_q <= 1'b0;
          state_q  <= ST_PROCESS;
        end
        ST_PROCESS: begin
          btnState_q <= btnState_d;
          cnt_q      <= cnt_d;
          timer_q    <= TMR_RELOAD;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          busReq_q <= 1'b0;
        end
      endcase
    end
  end

  // Setting wins over clearing so an overflow in the clear cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push && fifoFull && !evt_ready) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  evt_fifo #(
    .WIDTH(EVT_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_evt_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (evt_ready),
    .din  (evt),
    .full (fifoFull),
    .empty(fifoEmpty),
    .dout (evt_data)
  );

endmodule

// File: tb/tb_button_poll_master.sv
// Scoreboard bench for button_poll_master: directed button patterns with hand-computed events,
// popped and compared by an independent monitor whenever the consumer accepts an event.
module tb_button_poll_master;

  localparam int POLL_PERIOD = 4;
  localparam int DEBOUNCE    = 3;
  localparam int DEPTH       = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busReq;
  logic        busGnt;
  logic [15:0] addr;
  logic        en;
  logic        we;
  logic [15:0] data;
  logic [15:0] q;
  logic        evtValid;
  logic        evtReady = 1'b0;
  logic [15:0] evtData;
  logic [7:0]  btnState;
  logic        irq;
  logic        ovf;
  logic        ovfClr = 1'b0;

  logic        autoGrant = 1'b0;
  logic        manualGnt = 1'b0;
  logic [7:0]  btnLevels = 8'h00;
  logic [15:0] periphQ = 16'h0000;

  int          compared = 0;
  int          mismatched = 0;
  int          enPulses = 0;
  bit          tieViolated = 1'b0;
  logic [15:0] expQ [$];

  always #5 clk = ~clk;

  assign busGnt = autoGrant ? busReq : manualGnt;
  assign q      = periphQ;

  // Peripheral model: registers read data on the strobe edge; low byte is junk the DUT must ignore.
  always @(posedge clk) begin
    if (en === 1'b1) periphQ <= {btnLevels, 8'h5A};
  end

  button_poll_master #(
    .POLL_ADDR       (16'hF330),
    .POLL_PERIOD     (POLL_PERIOD),
    .DEBOUNCE_SAMPLES(DEBOUNCE),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_req  (busReq),
    .bus_gnt  (busGnt),
    .addr     (addr),
    .en       (en),
    .we       (we),
    .data     (data),
    .q        (q),
    .evt_valid(evtValid),
    .evt_ready(evtReady),
    .evt_data (evtData),
    .btn_state(btnState),
    .irq      (irq),
    .ovf      (ovf),
    .ovf_clr  (ovfClr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, required);
    end
  endtask

  // Monitor: an accepted handshake must present the oldest outstanding expected event.
  always @(negedge clk) begin
    #1;
    if (we !== 1'b0 || data !== 16'h0000) tieViolated = 1'b1;
    if (en === 1'b1) enPulses++;
    if (rst === 1'b0 && evtValid === 1'b1 && evtReady === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedEvent: got 'h%0h, expected no event", evtData);
      end else begin
        checkOutput("evtData", evtData, expQ.pop_front());
        checkOutput("irqWithEvent", irq, 1);
      end
    end
  end

  task automatic waitBusReq(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busReq !== 1'b1 && cycles < 50);
  endtask

  // One complete poll with the buttons at lv; optionally offer a pop in the PROCESS cycle.
  task automatic applyStimulus(input logic [7:0] lv, input bit popAtProcess);
    int guard = 0;
    btnLevels = lv;
    do begin
      @(negedge clk);
      guard++;
    end while (en !== 1'b1 && guard < 100);
    if (en !== 1'b1) begin
      checkOutput("pollTimeout", guard, 0);
      return;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (popAtProcess) evtReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (popAtProcess) evtReady = 1'b0;
  endtask

  task automatic polls(input logic [7:0] lv, input int n);
    for (int i = 0; i < n; i++) applyStimulus(lv, 1'b0);
  endtask

  initial begin
    int cycles;
    int pulsesBefore;

    #12;
    checkOutput("rstBusReq", busReq, 0);
    checkOutput("rstEn", en, 0);
    checkOutput("rstAddr", addr, 0);
    checkOutput("rstBtnState", btnState, 0);
    checkOutput("rstOvf", ovf, 0);
    checkOutput("rstEvtValid", evtValid, 0);
    checkOutput("rstIrq", irq, 0);
    checkOutput("rstEvtData", evtData, 0);

    @(negedge clk);
    rst = 1'b0;
    waitBusReq(cycles);
    checkOutput("firstReqDelay", cycles, POLL_PERIOD);

    // Grant held off: no strobe may appear while waiting.
    pulsesBefore = enPulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("heldOffEn", en, 0);
    end
    checkOutput("heldOffReq", busReq, 1);
    checkOutput("heldOffAddr", addr, 0);
    manualGnt = 1'b1;
    @(negedge clk);
    checkOutput("strobeEn", en, 1);
    checkOutput("strobeAddr", addr, 16'hF330);
    @(negedge clk);
    checkOutput("captureEn", en, 0);
    checkOutput("captureAddr", addr, 0);
    manualGnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    checkOutput("enPulseCount", enPulses - pulsesBefore, 1);

    // Reset in the middle of a strobe.
    waitBusReq(cycles);
    manualGnt = 1'b1;
    @(negedge clk);
    checkOutput("preResetEn", en, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstEn", en, 0);
    checkOutput("asyncRstBusReq", busReq, 0);
    checkOutput("asyncRstAddr", addr, 0);
    @(negedge clk);
    rst = 1'b0;
    manualGnt = 1'b0;
    checkOutput("postRstEvtValid", evtValid, 0);
    checkOutput("postRstIrq", irq, 0);
    waitBusReq(cycles);
    checkOutput("reqAfterReset", cycles, POLL_PERIOD);
    autoGrant = 1'b1;
    applyStimulus(8'h00, 1'b0);

    // Debounce: bigButton needs three consecutive polls.
    evtReady = 1'b1;
    expQ.push_back(16'h0100);
    polls(8'h01, 2);
    checkOutput("noEarlyFlip", btnState, 0);
    checkOutput("noEarlyEvt", evtValid, 0);
    applyStimulus(8'h01, 1'b0);
    checkOutput("bigButtonState", btnState, 8'h01);
    checkOutput("bigButtonEvtValid", evtValid, 1);

    // Two-poll glitch must not flip anything.
    polls(8'h00, 2);
    applyStimulus(8'h01, 1'b0);
    checkOutput("glitchState", btnState, 8'h01);
    checkOutput("glitchNoEvt", evtValid, 0);

    // Simultaneous morse_left press and bigButton release -> one combined event.
    expQ.push_back(16'h8001);
    polls(8'h80, 3);
    checkOutput("comboState", btnState, 8'h80);
    @(negedge clk);
    checkOutput("comboDrained", evtValid, 0);

    // Overflow with consumer stalled.
    evtReady = 1'b0;
    expQ.push_back(16'h0080);
    polls(8'h00, 3);
    expQ.push_back(16'h0200);
    polls(8'h02, 3);
    checkOutput("fullNoOvf", ovf, 0);
    checkOutput("fullEvtValid", evtValid, 1);
    polls(8'h00, 3);
    checkOutput("ovfSet", ovf, 1);
    checkOutput("ovfIrq", irq, 1);
    checkOutput("droppedStillUpdates", btnState, 8'h00);
    ovfClr = 1'b1;
    @(negedge clk);
    ovfClr = 1'b0;
    checkOutput("ovfCleared", ovf, 0);
    evtReady = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ovfDrained", evtValid, 0);

    // Full FIFO with pop and push in the same cycle.
    evtReady = 1'b0;
    expQ.push_back(16'h0400);
    polls(8'h04, 3);
    expQ.push_back(16'h0004);
    polls(8'h00, 3);
    expQ.push_back(16'h0800);
    polls(8'h08, 2);
    applyStimulus(8'h08, 1'b1);
    checkOutput("pushPopNoOvf", ovf, 0);
    checkOutput("pushPopValid", evtValid, 1);
    evtReady = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checkOutput("finalDrained", evtValid, 0);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    checkOutput("weDataTied", tieViolated, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
